// File: rtl/scpu_spi_lat_receiver.sv
// scpu_spi_lat_receiver: rebuilds the CPU's two-phase SPI configuration
// stream (SCLK1 capture, SCLK2 shift, LAT commit) into a parallel word.
//
// Ports:
//   CLK, RST_N        system clock, synchronous active-low reset
//   SCLK1, SCLK2      phase-1 capture / phase-2 shift clocks (asynchronous)
//   LAT               frame latch strobe (asynchronous)
//   SPI_SO            serial data, MSB first (asynchronous)
//   DOUT              last committed configuration word
//   DOUT_VLD          one-cycle pulse when DOUT is updated
//   FRAME_ERR         sticky protocol-error flag
//   BIT_CNT           bits shifted into the current frame (saturating)
//   BUSY              a frame is in progress
module scpu_spi_lat_receiver #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = $clog2(DATA_WIDTH + 2)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  SCLK1,
    input  logic                  SCLK2,
    input  logic                  LAT,
    input  logic                  SPI_SO,
    output logic [DATA_WIDTH-1:0] DOUT,
    output logic                  DOUT_VLD,
    output logic                  FRAME_ERR,
    output logic [CNT_WIDTH-1:0]  BIT_CNT,
    output logic                  BUSY
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPT,
        S_SHFT,
        S_CMT
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(DATA_WIDTH + 1);

    // ------------------------------------------------------------------
    // Input synchronisers and edge-detect history
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk1_sync_q;
    logic [SYNC_STAGES-1:0] sclk2_sync_q;
    logic [SYNC_STAGES-1:0] lat_sync_q;
    logic [SYNC_STAGES-1:0] so_sync_q;
    logic                   sclk1_prev_q;
    logic                   sclk2_prev_q;
    logic                   lat_prev_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sclk1_sync_q <= '0;
            sclk2_sync_q <= '0;
            lat_sync_q   <= '0;
            so_sync_q    <= '0;
            sclk1_prev_q <= 1'b0;
            sclk2_prev_q <= 1'b0;
            lat_prev_q   <= 1'b0;
        end else begin
            sclk1_sync_q <= {sclk1_sync_q[SYNC_STAGES-2:0], SCLK1};
            sclk2_sync_q <= {sclk2_sync_q[SYNC_STAGES-2:0], SCLK2};
            lat_sync_q   <= {lat_sync_q[SYNC_STAGES-2:0], LAT};
            so_sync_q    <= {so_sync_q[SYNC_STAGES-2:0], SPI_SO};
            sclk1_prev_q <= sclk1_sync_q[SYNC_STAGES-1];
            sclk2_prev_q <= sclk2_sync_q[SYNC_STAGES-1];
            lat_prev_q   <= lat_sync_q[SYNC_STAGES-1];
        end
    end

    logic sclk1_s;
    logic sclk2_s;
    logic lat_s;
    logic so_s;
    logic sclk1_rise;
    logic sclk2_rise;
    logic lat_rise;

    assign sclk1_s = sclk1_sync_q[SYNC_STAGES-1];
    assign sclk2_s = sclk2_sync_q[SYNC_STAGES-1];
    assign lat_s   = lat_sync_q[SYNC_STAGES-1];
    // Data comes out of the same stage as SCLK1 so capture sees the
    // value that was on the pin alongside the SCLK1 edge.
    assign so_s    = so_sync_q[SYNC_STAGES-1];

    assign sclk1_rise = sclk1_s & ~sclk1_prev_q;
    assign sclk2_rise = sclk2_s & ~sclk2_prev_q;
    assign lat_rise   = lat_s & ~lat_prev_q;

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    state_e                 state_q,  state_d;
    logic [DATA_WIDTH-1:0]  shreg_q,  shreg_d;
    logic                   master_q, master_d;
    logic [CNT_WIDTH-1:0]   cnt_q,    cnt_d;
    logic [DATA_WIDTH-1:0]  dout_q,   dout_d;
    logic                   vld_q,    vld_d;
    logic                   err_q,    err_d;
    logic                   viol;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            master_q <= 1'b0;
            cnt_q    <= '0;
            dout_q   <= '0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            master_q <= master_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
        end
    end

    // Phase-order violations abort the frame ahead of any other event.
    assign viol = (sclk1_rise & sclk2_rise)
                | ((state_q == S_CAPT) & (sclk1_rise | lat_rise))
                | (((state_q == S_IDLE) | (state_q == S_SHFT))
                   & sclk2_rise);

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        master_d = master_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        vld_d    = 1'b0;
        err_d    = err_q;

        if (viol) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (lat_rise) begin
                        // Latch with nothing shifted: flag, stay idle.
                        err_d = 1'b1;
                    end else if (sclk1_rise) begin
                        master_d = so_s;
                        state_d  = S_CAPT;
                    end
                end
                S_CAPT: begin
                    if (sclk2_rise) begin
                        shreg_d = {shreg_q[DATA_WIDTH-2:0], master_q};
                        // Saturate one past full so overflow is
                        // distinguishable from an exact frame.
                        cnt_d   = (cnt_q == CNT_MAX) ? CNT_MAX
                                                     : cnt_q + 1'b1;
                        state_d = S_SHFT;
                    end
                end
                S_SHFT: begin
                    if (lat_rise) begin
                        state_d = S_CMT;
                    end else if (sclk1_rise) begin
                        master_d = so_s;
                        state_d  = S_CAPT;
                    end
                end
                S_CMT: begin
                    if (cnt_q == CNT_FULL) begin
                        dout_d = shreg_q;
                        vld_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign DOUT      = dout_q;
    assign DOUT_VLD  = vld_q;
    assign FRAME_ERR = err_q;
    assign BIT_CNT   = cnt_q;
    assign BUSY      = (state_q != S_IDLE);

endmodule

// File: tb/tb_scpu_spi_lat_receiver.sv
// tb_scpu_spi_lat_receiver: directed and randomized frames against a
// queue-based frame model.
`timescale 1ns/1ps
module tb_scpu_spi_lat_receiver;

    localparam int DW   = 16;
    localparam int SS   = 2;
    localparam int CW   = $clog2(DW + 2);
    localparam int HOLD = SS + 2;

    logic          CLK    = 1'b0;
    logic          RST_N  = 1'b0;
    logic          SCLK1  = 1'b0;
    logic          SCLK2  = 1'b0;
    logic          LAT    = 1'b0;
    logic          SPI_SO = 1'b0;
    logic [DW-1:0] DOUT;
    logic          DOUT_VLD;
    logic          FRAME_ERR;
    logic [CW-1:0] BIT_CNT;
    logic          BUSY;

    int n_chk  = 0;
    int n_pass = 0;
    int vld_seen = 0;

    // Reference model: bits of the open frame, committed word, error flag
    bit            mq[$];
    logic [DW-1:0] m_dout;
    bit            m_err;

    always #5 CLK = ~CLK;

    scpu_spi_lat_receiver #(
        .DATA_WIDTH  (DW),
        .SYNC_STAGES (SS),
        .CNT_WIDTH   (CW)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .SCLK1     (SCLK1),
        .SCLK2     (SCLK2),
        .LAT       (LAT),
        .SPI_SO    (SPI_SO),
        .DOUT      (DOUT),
        .DOUT_VLD  (DOUT_VLD),
        .FRAME_ERR (FRAME_ERR),
        .BIT_CNT   (BIT_CNT),
        .BUSY      (BUSY)
    );

    always @(posedge CLK) begin
        #1;
        if (DOUT_VLD === 1'b1) vld_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    function automatic int m_cnt();
        return (mq.size() > DW + 1) ? DW + 1 : mq.size();
    endfunction

    // Only meaningful for an exact frame: first bit sent is the MSB.
    function automatic logic [DW-1:0] m_word();
        logic [DW-1:0] w = '0;
        for (int k = 0; k < DW; k++) w[DW-1-k] = mq[k];
        return w;
    endfunction

    task automatic hold(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_dout"}, DOUT, m_dout);
        check({tag, "_err"}, FRAME_ERR, m_err);
        check({tag, "_cnt"}, BIT_CNT, m_cnt());
        check({tag, "_busy"}, BUSY, m_cnt() > 0);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        hold(1);
        RST_N = 1'b1;
        m_dout = '0;
        m_err  = 1'b0;
        mq.delete();
        check("rst_vld", DOUT_VLD, 0);
        check_state("rst");
    endtask

    task automatic send_bit(input bit b);
        SPI_SO = b;
        SCLK1 = 1'b1; hold(HOLD);
        SCLK1 = 1'b0; hold(HOLD);
        SCLK2 = 1'b1; hold(HOLD);
        SCLK2 = 1'b0; hold(HOLD);
        mq.push_back(b);
    endtask

    task automatic send_word(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic do_lat();
        bit            ev;
        logic [DW-1:0] ed;
        int            v0;
        check_state("prelat");
        ev = (mq.size() == DW);
        ed = ev ? m_word() : m_dout;
        if (!ev) m_err = 1'b1;
        m_dout = ed;
        mq.delete();
        v0 = vld_seen;
        LAT = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            hold(1);
            if (k == 4) begin
                check("lat_vld", DOUT_VLD, ev);
                check("lat_dout", DOUT, ed);
                check("lat_err", FRAME_ERR, m_err);
            end else begin
                check("lat_vld_off", DOUT_VLD, 0);
            end
        end
        LAT = 1'b0;
        hold(HOLD);
        check("lat_pulses", vld_seen - v0, ev);
        check_state("postlat");
    endtask

    task automatic m_viol();
        m_err = 1'b1;
        mq.delete();
    endtask

    task automatic do_viol(input int kind);
        int v0 = vld_seen;
        case (kind)
            0: begin
                SPI_SO = 1'($urandom);
                SCLK1 = 1'b1; hold(HOLD);
                SCLK1 = 1'b0; hold(HOLD);
                SCLK1 = 1'b1; hold(HOLD);
                SCLK1 = 1'b0; hold(HOLD);
            end
            1: begin
                SCLK1 = 1'b1; SCLK2 = 1'b1; hold(HOLD);
                SCLK1 = 1'b0; SCLK2 = 1'b0; hold(HOLD);
            end
            2: begin
                SCLK2 = 1'b1; hold(HOLD);
                SCLK2 = 1'b0; hold(HOLD);
            end
            default: begin
                SCLK1 = 1'b1; hold(HOLD);
                SCLK1 = 1'b0; hold(HOLD);
                LAT = 1'b1; hold(HOLD);
                LAT = 1'b0; hold(HOLD);
            end
        endcase
        m_viol();
        check("viol_pulses", vld_seen - v0, 0);
        check_state("viol");
    endtask

    initial begin
        int len;
        int vat;
        int rat;
        hold(2);
        do_reset();

        // Good frame, then short frame, then recovery frame
        send_word(32'hA5C3, 16);
        do_lat();
        send_word(32'hFFF, 12);
        do_lat();
        send_word(32'h1234, 16);
        do_lat();

        // Overflow: 17 bits
        send_word($urandom, 17);
        do_lat();

        // Phase violations from a fresh reset
        do_reset();
        do_viol(0);
        do_reset();
        do_viol(1);
        do_reset();
        do_viol(2);
        do_reset();
        do_viol(3);

        // Reset mid-frame, then good frame
        do_reset();
        send_word(32'h5A, 8);
        do_reset();
        send_word(32'h00FF, 16);
        do_lat();

        // Idle LAT
        do_lat();

        // Randomized frames
        for (int f = 0; f < 30; f++) begin
            len = ($urandom_range(0, 9) < 7) ? DW
                                             : $urandom_range(0, DW + 2);
            vat = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1;
            rat = ($urandom_range(0, 15) == 0) ? $urandom_range(0, len) : -1;
            for (int i = 0; i <= len; i++) begin
                if (i == vat) do_viol($urandom_range(0, 3));
                if (i == rat) do_reset();
                if (i < len) send_bit(1'($urandom));
            end
            do_lat();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
